// File: rtl/playback_buffer.sv
// Circular FIFO with 1-cycle registered read port, sticky overflow/underflow flags and a
// free-running playback interval timer for the save/playback controller.
module playback_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int TIMER_CYCLES = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         write_enable,
  input  logic                         read_enable,
  input  logic                         timer_enable,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         timer,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMER_CYCLES);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  overflow_q, underflow_q;
  logic [TW-1:0]         tmr_cnt_q;
  logic                  timer_q;
  logic                  rd_acc, wr_acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A read while full frees the slot the concurrent write lands in; no bypass when empty.
  always_comb begin
    rd_acc  = read_enable && !empty;
    wr_acc  = write_enable && (!full || rd_acc);
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!clear && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_valid_q <= rd_acc;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        data_out_q <= mem_q[rd_ptr_q];
      end
      if (write_enable && !wr_acc) overflow_q  <= 1'b1;
      if (read_enable && !rd_acc)  underflow_q <= 1'b1;
    end
  end

  // Pulse lands TIMER_CYCLES edges after timer_enable rises, then every TIMER_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_cnt_q <= '0;
      timer_q   <= 1'b0;
    end else if (clear || !timer_enable) begin
      tmr_cnt_q <= '0;
      timer_q   <= 1'b0;
    end else if (tmr_cnt_q == TW'(TIMER_CYCLES - 1)) begin
      tmr_cnt_q <= '0;
      timer_q   <= 1'b1;
    end else begin
      tmr_cnt_q <= tmr_cnt_q + 1'b1;
      timer_q   <= 1'b0;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign timer      = timer_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_playback_buffer.sv
// Directed bench for playback_buffer: vector table for FIFO traffic plus hand sequences
// for async reset, clear and the interval timer.
module tb_playback_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       write_enable = 1'b0;
  logic       read_enable = 1'b0;
  logic       timer_enable = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_valid, empty, full, timer, overflow, underflow;
  logic [3:0] count;

  int n_total = 0;
  int n_pass  = 0;

  playback_buffer #(.DATA_WIDTH(8), .DEPTH(8), .TIMER_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .write_enable(write_enable), .read_enable(read_enable), .timer_enable(timer_enable),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .empty(empty), .full(full), .count(count), .timer(timer),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we, re, cl;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dv;
    logic [3:0] cnt;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, re, cl, input logic [7:0] din,
                     input logic [7:0] dout, input logic dv, input int cnt,
                     input logic ovf, unf);
    vec_t v;
    v.we = we; v.re = re; v.cl = cl; v.din = din;
    v.dout = dout; v.dv = dv; v.cnt = 4'(cnt); v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic we, re, cl, te, input logic [7:0] din);
    write_enable = we; read_enable = re; clear = cl; timer_enable = te; data_in = din;
    @(posedge clk);
    #1;
    write_enable = 1'b0; read_enable = 1'b0; clear = 1'b0; data_in = '0;
  endtask

  initial begin
    logic [7:0] tail [8];
    logic [7:0] seg4 [8];
    string tag;

    // Fill/drain order
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(17 * k), 8'h00, 0, k, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'h00, 8'(17 * k), 1, 8 - k, 0, 0);
    add(0, 0, 0, 8'h00, 8'h88, 0, 0, 0, 0);
    // Overflow and pointer wrap
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(17 * k), 8'h88, 0, k, 0, 0);
    add(1, 0, 0, 8'hAA, 8'h88, 0, 8, 1, 0);
    for (int k = 1; k <= 3; k++) add(0, 1, 0, 8'h00, 8'(17 * k), 1, 8 - k, 1, 0);
    add(1, 0, 0, 8'hB1, 8'h33, 0, 6, 1, 0);
    add(1, 0, 0, 8'hB2, 8'h33, 0, 7, 1, 0);
    add(1, 0, 0, 8'hB3, 8'h33, 0, 8, 1, 0);
    tail = '{8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hB1, 8'hB2, 8'hB3};
    for (int k = 0; k < 8; k++) add(0, 1, 0, 8'h00, tail[k], 1, 7 - k, 1, 0);
    // Simultaneous write+read while empty: write only, underflow
    add(1, 1, 0, 8'h5A, 8'hB3, 0, 1, 1, 1);
    add(0, 1, 0, 8'h00, 8'h5A, 1, 0, 1, 1);
    add(0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
    // Simultaneous write+read while full
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 8'(17 * k), 8'h00, 0, k, 0, 0);
    add(1, 1, 0, 8'hCC, 8'h11, 1, 8, 0, 0);
    seg4 = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hCC};
    for (int k = 0; k < 8; k++) add(0, 1, 0, 8'h00, seg4[k], 1, 7 - k, 0, 0);

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(data_out), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].cl, 1'b0, vecs[i].din);
      tag = $sformatf("v%0d", i);
      chk({tag, "_dout"}, 32'(data_out), 32'(vecs[i].dout));
      chk({tag, "_dv"}, 32'(data_valid), 32'(vecs[i].dv));
      chk({tag, "_count"}, 32'(count), 32'(vecs[i].cnt));
      chk({tag, "_empty"}, 32'(empty), 32'(vecs[i].cnt == 0));
      chk({tag, "_full"}, 32'(full), 32'(vecs[i].cnt == 8));
      chk({tag, "_ovf"}, 32'(overflow), 32'(vecs[i].ovf));
      chk({tag, "_unf"}, 32'(underflow), 32'(vecs[i].unf));
    end

    // Clear mid-operation with a concurrent write; underflow set first to see it cleared
    step(0, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 3; k++) step(1, 0, 0, 0, 8'(k));
    chk("pre_clr_count", 32'(count), 3);
    chk("pre_clr_unf", 32'(underflow), 1);
    step(1, 0, 1, 0, 8'hEE);
    chk("clr_count", 32'(count), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_unf", 32'(underflow), 0);
    step(0, 1, 0, 0, 8'h00);
    chk("clr_no_write_dv", 32'(data_valid), 0);

    // Async reset mid-run with count=5
    step(0, 0, 1, 0, 8'h00);
    for (int k = 1; k <= 6; k++) step(1, 0, 0, 0, 8'(17 * k));
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h77);
    step(1, 0, 0, 0, 8'h88);
    step(1, 0, 0, 0, 8'h99);
    step(1, 0, 0, 0, 8'hAB);
    chk("pre_arst_count", 32'(count), 8);
    chk("pre_arst_ovf", 32'(overflow), 1);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    chk("pre_arst_count5", 32'(count), 5);
    chk("pre_arst_dout", 32'(data_out), 32'h44);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_timer", 32'(timer), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_unf", 32'(underflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Timer: pulses every 4 edges while enabled
    for (int c = 1; c <= 12; c++) begin
      step(0, 0, 0, 1, 8'h00);
      chk($sformatf("tmr_run_c%0d", c), 32'(timer), 32'(c % 4 == 0));
    end
    step(0, 0, 0, 0, 8'h00);
    chk("tmr_off", 32'(timer), 0);
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0, 1, 8'h00);
      chk($sformatf("tmr_a_c%0d", c), 32'(timer), 32'(c == 4));
    end
    step(0, 0, 0, 0, 8'h00);
    chk("tmr_drop", 32'(timer), 0);
    for (int c = 1; c <= 5; c++) begin
      step(0, 0, 0, 1, 8'h00);
      chk($sformatf("tmr_b_c%0d", c), 32'(timer), 32'(c == 4));
    end
    timer_enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
